// File: rtl/motor_pkg.sv
// Shared types and constants for the line-following motor sequencer.
package motor_pkg;

    localparam int DEFAULT_PERIOD       = 2_000_000;
    localparam int DEFAULT_LOST_PERIODS = 25;
    localparam int COUNT_W              = 21;

    typedef enum logic [2:0] {
        STOP = 3'd0,
        FWD  = 3'd1,
        GL   = 3'd2,
        SL   = 3'd3,
        GR   = 3'd4,
        SR   = 3'd5
    } drive_state_t;

    // Sensor patterns, bit order {left, mid, right}.
    localparam logic [2:0] SNS_NONE      = 3'b000;
    localparam logic [2:0] SNS_RIGHT     = 3'b001;
    localparam logic [2:0] SNS_CENTER    = 3'b010;
    localparam logic [2:0] SNS_MID_RIGHT = 3'b011;
    localparam logic [2:0] SNS_LEFT      = 3'b100;
    localparam logic [2:0] SNS_SPLIT     = 3'b101;
    localparam logic [2:0] SNS_LEFT_MID  = 3'b110;
    localparam logic [2:0] SNS_ALL       = 3'b111;

    // Command word is {left_direction, left_brake, right_direction, right_brake}.
    function automatic logic [3:0] cmd_for(input drive_state_t s);
        logic [3:0] c;
        c = 4'b0101;
        case (s)
            STOP:    c = 4'b0101;
            FWD:     c = 4'b1000;
            GL:      c = 4'b0100;
            SL:      c = 4'b0000;
            GR:      c = 4'b1001;
            SR:      c = 4'b1010;
            default: c = 4'b0101;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bundle of slow asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/motor_sequencer.sv
// Frame-based drive sequencer: steers two servo motors from three line sensors,
// changing commands only at servo frame boundaries.
module motor_sequencer
    import motor_pkg::*;
#(
    parameter int PERIOD       = DEFAULT_PERIOD,
    parameter int LOST_PERIODS = DEFAULT_LOST_PERIODS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [2:0]          sensor,
    output logic [COUNT_W-1:0]  count_out,
    output logic                motor_reset,
    output logic                left_direction,
    output logic                left_brake,
    output logic                right_direction,
    output logic                right_brake,
    output logic [2:0]          state_dbg
);

    localparam int LOST_W = $clog2(LOST_PERIODS + 1);
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PERIOD - 1);
    localparam logic [LOST_W-1:0]  LOST_MAX   = LOST_W'(LOST_PERIODS);
    localparam logic [LOST_W-1:0]  LOST_LIMIT = LOST_W'(LOST_PERIODS - 1);

    logic [3:0]         sync_out;
    logic               run_s;
    logic [2:0]         sensor_s;

    logic [COUNT_W-1:0] count_q, count_d;
    logic               motor_reset_q;
    logic               frame_end;
    drive_state_t       state_q, state_d;
    logic [LOST_W-1:0]  lost_q, lost_d;
    logic [3:0]         cmd_q;

    sync2 #(.WIDTH(4)) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    ({run, sensor}),
        .q_o    (sync_out)
    );

    assign run_s    = sync_out[3];
    assign sensor_s = sync_out[2:0];

    assign frame_end = (count_q == LAST_COUNT);

    always_comb begin
        count_d = frame_end ? '0 : count_q + 1'b1;
    end

    // Next-state decode; only consumed on the frame_end edge.
    always_comb begin
        state_d = state_q;
        lost_d  = '0;
        if (!run_s) begin
            state_d = STOP;
        end else begin
            case (sensor_s)
                SNS_CENTER, SNS_ALL: state_d = FWD;
                SNS_LEFT_MID:        state_d = GL;
                SNS_LEFT:            state_d = SL;
                SNS_MID_RIGHT:       state_d = GR;
                SNS_RIGHT:           state_d = SR;
                SNS_SPLIT:           state_d = state_q;
                SNS_NONE: begin
                    if (lost_q >= LOST_LIMIT) begin
                        lost_d  = LOST_MAX;
                        state_d = STOP;
                    end else begin
                        lost_d  = lost_q + 1'b1;
                    end
                end
                default:             state_d = state_q;
            endcase
        end
    end

    // motor_reset is registered from count_d so it tracks count_q == PERIOD-1,
    // and its reset value of 1 covers the first cycle after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q       <= '0;
            motor_reset_q <= 1'b1;
            state_q       <= STOP;
            lost_q        <= '0;
            cmd_q         <= cmd_for(STOP);
        end else begin
            count_q       <= count_d;
            motor_reset_q <= (count_d == LAST_COUNT);
            if (frame_end) begin
                state_q <= state_d;
                lost_q  <= lost_d;
                cmd_q   <= cmd_for(state_d);
            end
        end
    end

    assign count_out       = count_q;
    assign motor_reset     = motor_reset_q;
    assign left_direction  = cmd_q[3];
    assign left_brake      = cmd_q[2];
    assign right_direction = cmd_q[1];
    assign right_brake     = cmd_q[0];
    assign state_dbg       = state_q;

endmodule

// File: doc/motor_sequencer.md
MOTOR_SEQUENCER -- requirements
Module: motor_sequencer

Interface
REQ-001 Parameter: PERIOD, 2_000_000, servo frame length in clk cycles (20 ms at 100 MHz).
REQ-002 Parameter: LOST_PERIODS, 25, consecutive line-lost frames tolerated before forced stop.
REQ-003 Clocking: one clock and one reset only; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  system clock, all state on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: run  input  1  enable driving; asynchronous to clk.
REQ-007 Port: sensor  input  3  line sensors {left, mid, right}; 1 = line seen; asynchronous to clk.
REQ-008 Port: count_out  output  21  frame timebase, shared by both motor pulse generators.
REQ-009 Port: motor_reset  output  1  frame-restart strobe to both motor pulse generators.
REQ-010 Port: left_direction, left_brake  output  1 each  left motor command.
REQ-011 Port: right_direction, right_brake  output  1 each  right motor command.

Function
REQ-012 The block SHALL pass run and sensor through a 2-flop synchronizer before any use.
REQ-013 count_out SHALL increment by 1 per cycle over 0..PERIOD-1 and wrap from PERIOD-1 to 0.
REQ-014 motor_reset SHALL be 1 exactly in cycles where count_out == PERIOD-1, else 0.
REQ-015 The synchronized run and sensor SHALL be sampled only in the cycle where count_out == PERIOD-1.
REQ-016 State register and all four command outputs SHALL update only on the edge where count_out wraps to 0; commands never change mid-frame.
REQ-017 The FSM SHALL have states STOP, FWD, GL (gentle left), SL (sharp left), GR (gentle right), SR (sharp right).
REQ-018 Sampled run = 0 SHALL force next state STOP regardless of sensor.
REQ-019 With run = 1, sampled sensor SHALL select: 010 or 111 -> FWD; 110 -> GL; 100 -> SL; 011 -> GR; 001 -> SR; 101 -> hold current state.
REQ-020 Sensor 000 SHALL increment a lost-frame counter and hold the current state; on the frame where the counter reaches LOST_PERIODS, the next state SHALL be STOP, and the counter SHALL saturate.
REQ-021 Any sampled sensor other than 000, or run = 0, SHALL clear the lost-frame counter.
REQ-022 Saturated lost counter with sensor still 000 SHALL keep STOP; leaving STOP requires a non-000 pattern.
REQ-023 Outputs {left_direction, left_brake, right_direction, right_brake} per state: STOP 0101; FWD 1000; GL 0100; SL 0000; GR 1001; SR 1010.

Reset
REQ-024 While reset_n = 0: count_out = 0, motor_reset = 1, state = STOP, commands = 0101, lost counter = 0, synchronizer flops = 0.
REQ-025 In the first cycle after reset_n rises, motor_reset SHALL stay 1; count_out SHALL advance to 1 on the following edge, and motor_reset SHALL then be 0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately, with no wait for a frame boundary.

Structure
REQ-027 Package motor_pkg SHALL hold the drive_state_t enum, PERIOD and LOST_PERIODS defaults, and the 3-bit sensor pattern constants.
REQ-028 The synchronizer SHALL be the single sub-module sync2, parameterized by width and instantiated once at width 4 for {run, sensor}.
REQ-029 The command outputs SHALL be registered; no combinational path from the inputs to the outputs.

Verification (bench overrides PERIOD = 100, LOST_PERIODS = 3)
REQ-030 Reset release, then 250 cycles -> count_out wraps 99->0 twice; motor_reset is high only at count 99 and in the first post-reset cycle.
REQ-031 run = 1, sensor = 010 held -> commands 1000 from the first wrap after sampling; sensor changed to 110 at count 40 -> commands stay 1000 until the next wrap, then 0100.
REQ-032 From FWD, sensor = 000 for 3 frames -> FWD held for 2 frames, STOP (0101) after the 3rd sample; then sensor = 001 -> SR (1010) at the next wrap.
REQ-033 From GR, sensor = 101 -> GR held; run = 0 with sensor = 010 -> STOP at the next wrap.
REQ-034 reset_n pulsed low at count_out = 57 in state SL -> commands 0101 and count_out 0 immediately, without waiting for a clock edge.
REQ-035 sensor toggled at count 98 (two cycles before sampling) -> the old pattern is sampled, confirming the 2-cycle synchronizer latency.
